// File: rtl/rgb_pwm_pkg.sv
// rtl/rgb_pwm_pkg.sv - shared constants for the rgb_pwm channel
package rgb_pwm_pkg;

  // Default width of the period counter and of the countmax/hivalue inputs.
  localparam int RGB_PWM_WIDTH = 16;

endpackage

// File: rtl/rgb_pwm.sv
// rtl/rgb_pwm.sv - single-colour PWM generator with period-boundary shadowing
//
// Free-running period counter compared against a shadowed high-time.
// countmax/hivalue are captured only at period boundaries, so they may be
// changed at any time without producing runt or stretched pulses.
//
// Ports:
//   clk       - single clock, all state changes on its rising edge
//   reset     - synchronous, active-high reset
//   countmax  - requested period in clk cycles (0 = channel disabled)
//   hivalue   - requested high-time in clk cycles
//   outpulse  - PWM output
//   nopulse   - high when the current period has no rising edge on outpulse
module rgb_pwm
  import rgb_pwm_pkg::*;
#(
  parameter int WIDTH = RGB_PWM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] countmax,
  input  logic [WIDTH-1:0] hivalue,
  output logic             outpulse,
  output logic             nopulse
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] per_q;
  logic [WIDTH-1:0] hi_q;
  logic             load;

  // A zero period reloads every cycle, so a disabled channel keeps polling
  // countmax until it becomes nonzero. Otherwise reload on the last count.
  assign load = (per_q == ZERO) || (cnt == (per_q - ONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      per_q <= '0;
      hi_q  <= '0;
    end else if (load) begin
      cnt   <= '0;
      per_q <= countmax;
      hi_q  <= hivalue;
    end else begin
      cnt   <= cnt + ONE;
    end
  end

  // Decoded from registers only; no path from countmax/hivalue.
  assign outpulse = (per_q != ZERO) && (cnt < hi_q);
  // hi_q >= per_q means the output is held high across the boundary,
  // so there is no rising edge in the period.
  assign nopulse  = (per_q == ZERO) || (hi_q == ZERO) || (hi_q >= per_q);

endmodule

// File: tb/tb_rgb_pwm.sv
// tb/tb_rgb_pwm.sv - directed self-checking bench for rgb_pwm
module tb_rgb_pwm;

  logic        clk;
  logic        reset;
  logic [15:0] countmax;
  logic [15:0] hivalue;
  logic        outpulse;
  logic        nopulse;

  int checks;
  int errors;

  rgb_pwm #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .countmax (countmax),
    .hivalue  (hivalue),
    .outpulse (outpulse),
    .nopulse  (nopulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sample len cycles on the falling edge, starting with the first cycle of a
  // period. Bit i of the captured mask is outpulse in cycle i. New inputs are
  // written right after the first sample so they land on the next load.
  task automatic run_period(input string tag, input int len, input logic [15:0] exp_mask,
                            input logic exp_nop, input logic [15:0] next_hi,
                            input logic [15:0] next_per);
    logic [15:0] pmask;
    logic [15:0] nmask;
    logic [15:0] nexp;
    pmask = '0;
    nmask = '0;
    nexp  = '0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      pmask[i] = outpulse;
      nmask[i] = nopulse;
      nexp[i]  = exp_nop;
      if (i == 0) begin
        hivalue  = next_hi;
        countmax = next_per;
      end
    end
    check({tag, "_pulse"}, {16'h0, pmask}, {16'h0, exp_mask});
    check({tag, "_nop"}, {16'h0, nmask}, {16'h0, nexp});
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    countmax = 16'd8;
    hivalue  = 16'd6;

    // Reset hold: outputs forced regardless of inputs.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_out", {31'h0, outpulse}, 32'd0);
      check("rst_nop", {31'h0, nopulse}, 32'd1);
    end
    reset = 1'b0;

    // Basic PWM 8/6: six high, two low.
    run_period("basic0", 8, 16'h003F, 1'b0, 16'd6, 16'd8);
    run_period("basic1", 8, 16'h003F, 1'b0, 16'd6, 16'd8);

    // Alternate hivalue each period; each period shows the previous write.
    run_period("glitch_a", 8, 16'h003F, 1'b0, 16'd3, 16'd8);
    run_period("glitch_b", 8, 16'h0007, 1'b0, 16'd6, 16'd8);
    run_period("glitch_c", 8, 16'h003F, 1'b0, 16'd3, 16'd8);
    run_period("glitch_d", 8, 16'h0007, 1'b0, 16'd6, 16'd8);

    // hivalue 0 -> stuck low; hivalue == countmax -> stuck high.
    run_period("pre_hi0", 8, 16'h003F, 1'b0, 16'd0, 16'd8);
    run_period("hi0",     8, 16'h0000, 1'b1, 16'd8, 16'd8);
    run_period("hi8",     8, 16'h00FF, 1'b1, 16'd8, 16'd0);

    // countmax 0 -> disabled; re-sampled every cycle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("cm0_out", {31'h0, outpulse}, 32'd0);
      check("cm0_nop", {31'h0, nopulse}, 32'd1);
      if (i == 2) begin
        countmax = 16'd4;
        hivalue  = 16'd1;
      end
    end
    // Pattern starts right after the next edge: 1 high, 3 low.
    run_period("cm4", 8, 16'h0011, 1'b0, 16'd1, 16'd4);
    run_period("cm4_to8", 4, 16'h0001, 1'b0, 16'd6, 16'd8);

    // Reset mid-period at cnt=3 of 8.
    run_period("pre_rst", 4, 16'h000F, 1'b0, 16'd6, 16'd8);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_out", {31'h0, outpulse}, 32'd0);
    check("midrst_nop", {31'h0, nopulse}, 32'd1);
    reset = 1'b0;
    run_period("post_rst", 8, 16'h003F, 1'b0, 16'd6, 16'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
